// File: rtl/lsu_aligned_pipe_if.sv
// Load/store operation encodings and the data-memory bus between the LSU and
// data memory. The LSU drives the request side through the master modport.
// The memory returns read data and ready through the slave modport.
package lsu_pkg;
   typedef enum logic [2:0] {
      LD_LB  = 3'd0,
      LD_LH  = 3'd1,
      LD_LW  = 3'd2,
      LD_LBU = 3'd4,
      LD_LHU = 3'd5
   } load_op_t;

   typedef enum logic [1:0] {
      ST_SB = 2'd0,
      ST_SH = 2'd1,
      ST_SW = 2'd2
   } store_op_t;
endpackage

interface lsu_mem_if;
   logic        d_req;
   logic [31:0] d_addr;
   logic [3:0]  d_we;
   logic [31:0] d_wr_data;
   logic [31:0] d_rd_data;
   logic        d_ready;

   modport master (
      output d_req, d_addr, d_we, d_wr_data,
      input  d_rd_data, d_ready
   );

   modport slave (
      input  d_req, d_addr, d_we, d_wr_data,
      output d_rd_data, d_ready
   );
endinterface

// File: rtl/lsu_aligned_pipe.sv
// Load/store unit between execute and data memory.
// The unit aligns sub-word accesses to byte lanes and faults on misaligned
// accesses. Loads travel through a fixed-latency pipe that matches the
// memory read latency. Loads still in flight are flagged as load-use hazards
// against the decode-stage sources.
module lsu_aligned_pipe
   import lsu_pkg::*;
#(
   parameter int RD_W        = 4,
   parameter int MEM_LAT     = 1,
   parameter int ALIGN_CHECK = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            lsu_en,
   input  logic [RD_W-1:0] rd,
   input  logic [31:0]     addr,
   input  logic            is_load_op,
   input  logic            is_store_op,
   input  load_op_t        load_op,
   input  store_op_t       store_op,
   input  logic [31:0]     write_data,
   input  logic [RD_W-1:0] rs1,
   input  logic [RD_W-1:0] rs2,
   output logic            ld_hazard,
   output logic            lsu_stall,
   output logic            ld_valid,
   output logic [RD_W-1:0] ld_rd,
   output logic [31:0]     ld_rd_data,
   output logic            ma_fault,
   output logic [31:0]     ma_addr,
   lsu_mem_if.master       mem
);

   localparam int LAST = MEM_LAT - 1;

   // Access size code: 0 = byte, 1 = half, 2 = word (unknown ops behave as word).
   function automatic logic [1:0] ld_size(input load_op_t op);
      case (op)
         LD_LB, LD_LBU: ld_size = 2'd0;
         LD_LH, LD_LHU: ld_size = 2'd1;
         default:       ld_size = 2'd2;
      endcase
   endfunction

   function automatic logic [1:0] st_size(input store_op_t op);
      case (op)
         ST_SB:   st_size = 2'd0;
         ST_SH:   st_size = 2'd1;
         default: st_size = 2'd2;
      endcase
   endfunction

   // Select the addressed lane and sign- or zero-extend it to 32 bits.
   function automatic logic [31:0] extend_lane(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input load_op_t    op);
      logic [31:0]        lane;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      lane = word >> {off, 3'b000};
      sb   = lane[7:0];
      sh   = lane[15:0];
      case (op)
         LD_LB:   extend_lane = 32'(sb);
         LD_LH:   extend_lane = 32'(sh);
         LD_LBU:  extend_lane = {24'd0, lane[7:0]};
         LD_LHU:  extend_lane = {16'd0, lane[15:0]};
         default: extend_lane = lane;
      endcase
   endfunction

   function automatic logic rd_match(input logic [RD_W-1:0] r,
                                     input logic [RD_W-1:0] s1,
                                     input logic [RD_W-1:0] s2);
      rd_match = (r != '0) && ((r == s1) || (r == s2));
   endfunction

   logic [1:0]  sz;
   logic        op_vld, misal, ld_acc, st_acc;
   logic [1:0]  off;
   logic [3:0]  we_mask;

   logic            vld_p [MEM_LAT];
   logic [RD_W-1:0] rd_p  [MEM_LAT];
   load_op_t        op_p  [MEM_LAT];
   logic [1:0]      off_p [MEM_LAT];

   // Request decode: size, misalignment, lane offset and byte-enable mask.
   always_comb begin
      sz      = is_load_op ? ld_size(load_op) : st_size(store_op);
      op_vld  = lsu_en & (is_load_op | is_store_op);
      misal   = 1'b0;
      off     = addr[1:0];
      if (ALIGN_CHECK != 0)
         misal = ((sz == 2'd1) & addr[0]) | ((sz == 2'd2) & (addr[1:0] != 2'b00));
      else if (sz == 2'd2)
         off = 2'b00;
      else if (sz == 2'd1)
         off = {addr[1], 1'b0};
      case (sz)
         2'd0:    we_mask = 4'b0001 << off;
         2'd1:    we_mask = 4'b0011 << off;
         default: we_mask = 4'b1111;
      endcase
   end

   assign mem.d_req     = op_vld & ~misal & ~rst;
   assign mem.d_addr    = {addr[31:2], 2'b00};
   assign lsu_stall     = mem.d_req & ~mem.d_ready;
   assign ld_acc        = mem.d_req & mem.d_ready & is_load_op;
   assign st_acc        = mem.d_req & mem.d_ready & ~is_load_op;
   assign mem.d_we      = st_acc ? we_mask : 4'b0000;
   assign mem.d_wr_data = (sz == 2'd0) ? {4{write_data[7:0]}} :
                          (sz == 2'd1) ? {2{write_data[15:0]}} : write_data;

   // Load pipe valids: stage 0 takes an accepted load; reset drops in-flight loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_LAT; i++) vld_p[i] <= 1'b0;
      end else begin
         vld_p[0] <= ld_acc;
         for (int i = 1; i < MEM_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   // Load pipe payload shifts alongside the valids.
   always_ff @(posedge clk) begin
      rd_p[0]  <= rd;
      op_p[0]  <= load_op;
      off_p[0] <= off;
      for (int i = 1; i < MEM_LAT; i++) begin
         rd_p[i]  <= rd_p[i-1];
         op_p[i]  <= op_p[i-1];
         off_p[i] <= off_p[i-1];
      end
   end

   // Final stage drives writeback; data is zero whenever no load completes.
   assign ld_valid   = vld_p[LAST];
   assign ld_rd      = vld_p[LAST] ? rd_p[LAST] : '0;
   assign ld_rd_data = vld_p[LAST] ? extend_lane(mem.d_rd_data, off_p[LAST], op_p[LAST]) : 32'd0;

   // Hazard: the load accepted now and every non-final in-flight stage.
   always_comb begin
      ld_hazard = ld_acc & rd_match(rd, rs1, rs2);
      for (int i = 0; i < LAST; i++)
         ld_hazard = ld_hazard | (vld_p[i] & rd_match(rd_p[i], rs1, rs2));
   end

   // Misalignment fault pulses one cycle after the offending op.
   always_ff @(posedge clk) begin
      if (rst) begin
         ma_fault <= 1'b0;
         ma_addr  <= 32'd0;
      end else begin
         ma_fault <= op_vld & misal;
         if (op_vld & misal) ma_addr <= addr;
      end
   end

endmodule

// File: tb/tb_lsu_aligned_pipe.sv
// Directed bench for lsu_aligned_pipe: a MEM_LAT=1 instance (u1) and a
// MEM_LAT=3 instance (u3) share the execute-side inputs, each with its own memory bus.
module tb_lsu_aligned_pipe;
   import lsu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, lsu_en, is_load_op, is_store_op;
   logic [3:0]  rd, rs1, rs2;
   logic [31:0] addr, write_data;
   load_op_t    load_op;
   store_op_t   store_op;

   lsu_mem_if m1();
   lsu_mem_if m3();

   logic        u1_ld_hazard, u1_lsu_stall, u1_ld_valid, u1_ma_fault;
   logic [3:0]  u1_ld_rd;
   logic [31:0] u1_ld_rd_data, u1_ma_addr;
   logic        u3_ld_hazard, u3_lsu_stall, u3_ld_valid, u3_ma_fault;
   logic [3:0]  u3_ld_rd;
   logic [31:0] u3_ld_rd_data, u3_ma_addr;

   int vec  = 0;
   int errs = 0;

   lsu_aligned_pipe #(.RD_W(4), .MEM_LAT(1), .ALIGN_CHECK(1)) u1 (
      .clk(clk), .rst(rst), .lsu_en(lsu_en), .rd(rd), .addr(addr),
      .is_load_op(is_load_op), .is_store_op(is_store_op), .load_op(load_op),
      .store_op(store_op), .write_data(write_data), .rs1(rs1), .rs2(rs2),
      .ld_hazard(u1_ld_hazard), .lsu_stall(u1_lsu_stall), .ld_valid(u1_ld_valid),
      .ld_rd(u1_ld_rd), .ld_rd_data(u1_ld_rd_data), .ma_fault(u1_ma_fault),
      .ma_addr(u1_ma_addr), .mem(m1)
   );

   lsu_aligned_pipe #(.RD_W(4), .MEM_LAT(3), .ALIGN_CHECK(1)) u3 (
      .clk(clk), .rst(rst), .lsu_en(lsu_en), .rd(rd), .addr(addr),
      .is_load_op(is_load_op), .is_store_op(is_store_op), .load_op(load_op),
      .store_op(store_op), .write_data(write_data), .rs1(rs1), .rs2(rs2),
      .ld_hazard(u3_ld_hazard), .lsu_stall(u3_lsu_stall), .ld_valid(u3_ld_valid),
      .ld_rd(u3_ld_rd), .ld_rd_data(u3_ld_rd_data), .ma_fault(u3_ma_fault),
      .ma_addr(u3_ma_addr), .mem(m3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      lsu_en = 0; is_load_op = 0; is_store_op = 0;
      rd = 0; rs1 = 0; rs2 = 0;
   endtask

   task automatic drive_load(input logic [2:0] op, input logic [31:0] a, input logic [3:0] r);
      lsu_en = 1; is_load_op = 1; is_store_op = 0;
      load_op = load_op_t'(op); addr = a; rd = r;
   endtask

   task automatic drive_store(input store_op_t op, input logic [31:0] a, input logic [31:0] wd);
      lsu_en = 1; is_load_op = 0; is_store_op = 1;
      store_op = op; addr = a; write_data = wd;
   endtask

   task automatic test_reset();
      rst = 1; idle();
      load_op = LD_LW; store_op = ST_SW; addr = 32'h100; write_data = 32'h0;
      m1.d_ready = 1; m3.d_ready = 1; m1.d_rd_data = 0; m3.d_rd_data = 0;
      drive_store(ST_SW, 32'h100, 32'h0);
      #1;
      vec++; if (m1.d_req !== 1'b0) begin errs++; $display("FAIL rst_d_req got %b want 0", m1.d_req); end
      vec++; if (m1.d_we !== 4'b0000) begin errs++; $display("FAIL rst_d_we got %b want 0000", m1.d_we); end
      tick(); tick();
      vec++; if (u1_ld_valid !== 1'b0) begin errs++; $display("FAIL rst_ld_valid got %b want 0", u1_ld_valid); end
      vec++; if (u1_ma_fault !== 1'b0) begin errs++; $display("FAIL rst_ma_fault got %b want 0", u1_ma_fault); end
      vec++; if (u1_ld_rd !== 4'd0) begin errs++; $display("FAIL rst_ld_rd got %0d want 0", u1_ld_rd); end
      vec++; if (u1_ma_addr !== 32'd0) begin errs++; $display("FAIL rst_ma_addr got %h want 0", u1_ma_addr); end
      vec++; if (u3_ld_valid !== 1'b0) begin errs++; $display("FAIL rst_u3_ld_valid got %b want 0", u3_ld_valid); end
      rst = 0; idle();
      tick();
   endtask

   task automatic test_store_word();
      drive_store(ST_SW, 32'h100, 32'hDEADBEEF);
      #1;
      vec++; if (m1.d_req !== 1'b1) begin errs++; $display("FAIL sw_d_req got %b want 1", m1.d_req); end
      vec++; if (m1.d_we !== 4'b1111) begin errs++; $display("FAIL sw_d_we got %b want 1111", m1.d_we); end
      vec++; if (m1.d_addr !== 32'h100) begin errs++; $display("FAIL sw_d_addr got %h want 00000100", m1.d_addr); end
      vec++; if (m1.d_wr_data !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_wr_data got %h want deadbeef", m1.d_wr_data); end
      vec++; if (u1_lsu_stall !== 1'b0) begin errs++; $display("FAIL sw_stall got %b want 0", u1_lsu_stall); end
      tick(); idle();
   endtask

   task automatic test_load_word();
      m1.d_rd_data = 32'hDEADBEEF;
      drive_load(3'd2, 32'h100, 4'd5);
      #1;
      vec++; if (m1.d_we !== 4'b0000) begin errs++; $display("FAIL lw_d_we got %b want 0000", m1.d_we); end
      vec++; if (u1_ld_rd_data !== 32'd0) begin errs++; $display("FAIL lw_idle_data got %h want 0", u1_ld_rd_data); end
      tick(); idle(); #1;
      vec++; if (u1_ld_valid !== 1'b1) begin errs++; $display("FAIL lw_valid got %b want 1", u1_ld_valid); end
      vec++; if (u1_ld_rd !== 4'd5) begin errs++; $display("FAIL lw_rd got %0d want 5", u1_ld_rd); end
      vec++; if (u1_ld_rd_data !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_data got %h want deadbeef", u1_ld_rd_data); end
      tick();
      vec++; if (u1_ld_valid !== 1'b0) begin errs++; $display("FAIL lw_valid_drop got %b want 0", u1_ld_valid); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  ops  [6] = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd0, 3'd3};
      logic [31:0] adrs [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
      logic [31:0] exps [6] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF,
                                32'hFFFF80FF, 32'h00000001, 32'h80FF0102};
      m1.d_rd_data = 32'h80FF0102;
      for (int i = 0; i < 6; i++) begin
         drive_load(ops[i], adrs[i], 4'd4);
         tick(); idle(); #1;
         vec++;
         if (u1_ld_valid !== 1'b1 || u1_ld_rd_data !== exps[i]) begin
            errs++;
            $display("FAIL load_ext[%0d] got valid=%b data=%h want valid=1 data=%h",
                     i, u1_ld_valid, u1_ld_rd_data, exps[i]);
         end
      end
      tick();
   endtask

   task automatic test_store_sub();
      drive_store(ST_SH, 32'h102, 32'h00001234);
      #1;
      vec++; if (m1.d_we !== 4'b1100) begin errs++; $display("FAIL sh_d_we got %b want 1100", m1.d_we); end
      vec++; if (m1.d_wr_data !== 32'h12341234) begin errs++; $display("FAIL sh_wr_data got %h want 12341234", m1.d_wr_data); end
      vec++; if (m1.d_addr !== 32'h100) begin errs++; $display("FAIL sh_d_addr got %h want 00000100", m1.d_addr); end
      tick();
      drive_store(ST_SB, 32'h101, 32'h000000AB);
      #1;
      vec++; if (m1.d_we !== 4'b0010) begin errs++; $display("FAIL sb_d_we got %b want 0010", m1.d_we); end
      vec++; if (m1.d_wr_data !== 32'hABABABAB) begin errs++; $display("FAIL sb_wr_data got %h want abababab", m1.d_wr_data); end
      tick(); idle();
   endtask

   task automatic test_misaligned();
      drive_load(3'd2, 32'h102, 4'd3);
      #1;
      vec++; if (m1.d_req !== 1'b0) begin errs++; $display("FAIL mis_d_req got %b want 0", m1.d_req); end
      tick(); idle(); #1;
      vec++; if (u1_ma_fault !== 1'b1) begin errs++; $display("FAIL mis_fault got %b want 1", u1_ma_fault); end
      vec++; if (u1_ma_addr !== 32'h102) begin errs++; $display("FAIL mis_addr got %h want 00000102", u1_ma_addr); end
      vec++; if (u1_ld_valid !== 1'b0) begin errs++; $display("FAIL mis_ld_valid got %b want 0", u1_ld_valid); end
      tick();
      vec++; if (u1_ma_fault !== 1'b0) begin errs++; $display("FAIL mis_pulse got %b want 0", u1_ma_fault); end
      drive_store(ST_SH, 32'h101, 32'h00005555);
      #1;
      vec++; if (m1.d_req !== 1'b0 || m1.d_we !== 4'b0000) begin
         errs++; $display("FAIL mis_sh got req=%b we=%b want req=0 we=0000", m1.d_req, m1.d_we);
      end
      tick(); idle(); tick();
   endtask

   task automatic test_back_to_back();
      m1.d_rd_data = 32'hCAFEF00D;
      drive_load(3'd2, 32'h100, 4'd1);
      tick();
      rd = 4'd2; #1;
      vec++; if (u1_ld_valid !== 1'b1 || u1_ld_rd !== 4'd1) begin
         errs++; $display("FAIL b2b_first got valid=%b rd=%0d want 1/1", u1_ld_valid, u1_ld_rd);
      end
      tick(); idle(); #1;
      vec++; if (u1_ld_valid !== 1'b1 || u1_ld_rd !== 4'd2) begin
         errs++; $display("FAIL b2b_second got valid=%b rd=%0d want 1/2", u1_ld_valid, u1_ld_rd);
      end
      tick();
   endtask

   task automatic test_rd0();
      drive_load(3'd2, 32'h100, 4'd0);
      #1;
      vec++; if (u1_ld_hazard !== 1'b0) begin errs++; $display("FAIL rd0_hazard got %b want 0", u1_ld_hazard); end
      tick(); idle(); #1;
      vec++; if (u1_ld_valid !== 1'b1 || u1_ld_rd !== 4'd0) begin
         errs++; $display("FAIL rd0_wb got valid=%b rd=%0d want 1/0", u1_ld_valid, u1_ld_rd);
      end
      drive_load(3'd2, 32'h100, 4'd6); rs2 = 4'd6;
      #1;
      vec++; if (u1_ld_hazard !== 1'b1) begin errs++; $display("FAIL acc_hazard got %b want 1", u1_ld_hazard); end
      tick(); idle();
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_stall_hazard();
      m3.d_ready = 0; m3.d_rd_data = 32'h11223344;
      drive_load(3'd2, 32'h200, 4'd7); rs1 = 4'd7;
      #1;
      vec++; if (u3_lsu_stall !== 1'b1) begin errs++; $display("FAIL stall_c0 got %b want 1", u3_lsu_stall); end
      vec++; if (u3_ld_hazard !== 1'b0) begin errs++; $display("FAIL stall_hz_c0 got %b want 0", u3_ld_hazard); end
      tick();
      vec++; if (u3_lsu_stall !== 1'b1) begin errs++; $display("FAIL stall_c1 got %b want 1", u3_lsu_stall); end
      tick();
      m3.d_ready = 1; #1;
      vec++; if (u3_lsu_stall !== 1'b0) begin errs++; $display("FAIL stall_c2 got %b want 0", u3_lsu_stall); end
      vec++; if (u3_ld_hazard !== 1'b1) begin errs++; $display("FAIL hz_accept got %b want 1", u3_ld_hazard); end
      tick(); idle(); rs2 = 4'd7; #1;
      vec++; if (u3_ld_hazard !== 1'b1 || u3_ld_valid !== 1'b0) begin
         errs++; $display("FAIL hz_stage0 got hz=%b valid=%b want 1/0", u3_ld_hazard, u3_ld_valid);
      end
      tick(); rs1 = 4'd7; rs2 = 4'd0; #1;
      vec++; if (u3_ld_hazard !== 1'b1 || u3_ld_valid !== 1'b0) begin
         errs++; $display("FAIL hz_stage1 got hz=%b valid=%b want 1/0", u3_ld_hazard, u3_ld_valid);
      end
      tick();
      vec++; if (u3_ld_valid !== 1'b1 || u3_ld_rd !== 4'd7 || u3_ld_rd_data !== 32'h11223344) begin
         errs++; $display("FAIL lat3_wb got valid=%b rd=%0d data=%h want 1/7/11223344",
                          u3_ld_valid, u3_ld_rd, u3_ld_rd_data);
      end
      vec++; if (u3_ld_hazard !== 1'b0) begin errs++; $display("FAIL hz_final got %b want 0", u3_ld_hazard); end
      tick();
      vec++; if (u3_ld_valid !== 1'b0) begin errs++; $display("FAIL lat3_drop got %b want 0", u3_ld_valid); end
      idle();
   endtask

   task automatic test_reset_midflight();
      drive_load(3'd2, 32'h200, 4'd9);
      tick(); idle(); rst = 1;
      tick(); rst = 0;
      for (int i = 0; i < 4; i++) begin
         vec++; if (u3_ld_valid !== 1'b0) begin errs++; $display("FAIL rst_flight[%0d] got %b want 0", i, u3_ld_valid); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_load_word();
      test_load_ext();
      test_store_sub();
      test_misaligned();
      test_back_to_back();
      test_rd0();
      test_stall_hazard();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
